memory_match_ctrl: RTL and testbench
====================================

// Module: memory_match_ctrl
// PURPOSE
//  Game-flow reader for the 4x4 memory-game board. It takes player card picks,
//  reads each picked card's 3-bit symbol from the board store over a 1-cycle
//  read port, and compares the two symbols. It then marks matched pairs, or
//  shows a mismatch for a timed interval before hiding the cards again.
//  It tracks the turn and the score of two players and flags the end of the game.
//  It sits between the pushbutton/selection logic and the display driver.
// PARAMETERS
//  SYM_W        3   symbol width read from board
//  SHOW_CYCLES  8   clk cycles a mismatched pair stays face-up (>=1)
//  SCORE_W      4   width of each player score counter
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low; clears all state
//  sel_valid   in   1       1-cycle pick strobe
//  sel_row     in   2       picked row, sampled when sel_valid=1
//  sel_col     in   2       picked column, sampled when sel_valid=1
//  rd_addr     out  4       board read address {row,col}
//  rd_data     in   SYM_W   board symbol at rd_addr, valid 1 cycle after rd_addr changes
//  face_up     out  16      bit {row,col}=1 when the card is shown (matched or currently picked)
//  matched     out  16      bit {row,col}=1 once the card is part of a matched pair
//  sym_a       out  SYM_W   symbol of the first pick of this turn
//  sym_b       out  SYM_W   symbol of the second pick of this turn
//  player      out  1       current turn (0/1)
//  score0      out  SCORE_W pairs won by player 0
//  score1      out  SCORE_W pairs won by player 1
//  match_pulse out  1       1-cycle strobe when a pair is confirmed
//  busy        out  1       1 in READ_A, READ_B, COMPARE, SHOW
//  game_over   out  1       1 in DONE
// BEHAVIOUR
//  Reset: all outputs 0 (rd_addr=0, face_up=0, matched=0, scores=0, player=0);
//   state=PICK_A; show counter=0. Reset asserted mid-turn or mid-SHOW aborts
//   immediately; no partial update survives.
//  States:
//   PICK_A -> READ_A -> PICK_B -> READ_B -> COMPARE -> {PICK_A | SHOW | DONE}
//  Pick acceptance (PICK_A or PICK_B only):
//   - a pick with sel_valid=1 and matched[{row,col}]=0 is accepted;
//   - in PICK_B, a pick equal to the first-pick address is also rejected;
//   - a rejected pick changes nothing.
//   On acceptance: rd_addr<={row,col}; face_up bit set; go to READ_x next cycle.
//  sel_valid in any other state is ignored (no queueing).
//  READ_A/READ_B: exactly 1 cycle. rd_data is captured into sym_a/sym_b at the
//   end of that cycle. Next state is PICK_B or COMPARE respectively.
//  COMPARE: 1 cycle; equality test over the full SYM_W bits.
//   - equal: set matched bits for both addresses; score[player]++;
//     match_pulse=1; same player keeps the turn.
//     Next state is DONE if the pair count reaches 8, otherwise PICK_A.
//   - unequal: go to SHOW; load the counter with SHOW_CYCLES-1.
//  SHOW: both cards stay face-up; the counter decrements each cycle.
//   On the cycle the counter is 0: clear both face_up bits (matched bits
//   unaffected); toggle player; go to PICK_A.
//  DONE: all outputs hold; only reset leaves it.
//  Scores saturate at 2^SCORE_W-1 (unreachable at defaults; still required).
//  face_up == matched | picked-this-turn bits at all times.
// TESTING
//  1 Reset: bench holds reset=0 with random sel_valid -> all outputs 0;
//    after release, state PICK_A with player=0.
//  2 Match: bench board has (0,0)=3 and (1,2)=3; pick (0,0), then (1,2) ->
//    match_pulse 1 cycle, matched=16'h0041, score0=1, player stays 0.
//  3 Mismatch: pick (0,0)=3, then (0,1)=5 -> face_up=16'h0003 held for
//    exactly 8 cycles, then 0; player=1; scores unchanged.
//  4 Illegal picks: repeat (0,0) as the second pick, pick an already-matched
//    card, and strobe sel_valid during SHOW -> no state, face_up or rd_addr change.
//  5 Full game: 8 sequential matches alternating with mismatches ->
//    game_over=1 after the 8th match_pulse; matched=16'hFFFF;
//    score0+score1=8; later picks ignored.
//  6 Reset mid-SHOW: assert reset 3 cycles into SHOW -> outputs clear
//    immediately; a new game runs normally after release.

Source files
------------

// File: rtl/memory_match_ctrl.sv
// Turn controller for the 4x4 memory game: reads two picked card symbols, compares them,
// marks matched pairs or shows a mismatch for a fixed interval, and keeps turn and score.
module memory_match_ctrl #(
   parameter int SYM_W       = 3,
   parameter int SHOW_CYCLES = 8,
   parameter int SCORE_W     = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_sel_valid,
   input  logic [1:0]         i_sel_row,
   input  logic [1:0]         i_sel_col,
   output logic [3:0]         o_rd_addr,
   input  logic [SYM_W-1:0]   i_rd_data,
   output logic [15:0]        o_face_up,
   output logic [15:0]        o_matched,
   output logic [SYM_W-1:0]   o_sym_a,
   output logic [SYM_W-1:0]   o_sym_b,
   output logic               o_player,
   output logic [SCORE_W-1:0] o_score0,
   output logic [SCORE_W-1:0] o_score1,
   output logic               o_match_pulse,
   output logic               o_busy,
   output logic               o_game_over
);

   // state   | meaning
   // PICK_A  | waiting for the first card of the turn
   // READ_A  | board returns the first symbol
   // PICK_B  | waiting for the second card (not the first, not matched)
   // READ_B  | board returns the second symbol
   // COMPARE | symbols compared, pair scored or mismatch shown
   // SHOW    | mismatched pair stays face-up until the counter expires
   // DONE    | all pairs found; held until reset
   typedef enum logic [2:0] {
      PICK_A, READ_A, PICK_B, READ_B, COMPARE, SHOW, DONE
   } state_t;

   localparam int CNT_W = $clog2(SHOW_CYCLES + 1);

   state_t             r_state, w_next;
   logic [3:0]         r_rd_addr, r_addr_a;
   logic [15:0]        r_face_up, r_matched;
   logic [SYM_W-1:0]   r_sym_a, r_sym_b;
   logic               r_player, r_match_pulse;
   logic [SCORE_W-1:0] r_score0, r_score1;
   logic [CNT_W-1:0]   r_cnt;

   logic [3:0]  w_sel_addr;
   logic [15:0] w_pair_mask;
   logic        w_accept, w_match, w_show_load, w_show_end;

   assign w_sel_addr  = {i_sel_row, i_sel_col};
   assign w_pair_mask = (16'd1 << r_addr_a) | (16'd1 << r_rd_addr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= PICK_A;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_match     = 1'b0;
      w_show_load = 1'b0;
      w_show_end  = 1'b0;
      case (r_state)
         PICK_A: begin
            if (i_sel_valid && !r_matched[w_sel_addr]) begin
               w_accept = 1'b1;
               w_next   = READ_A;
            end
         end
         READ_A: w_next = PICK_B;
         PICK_B: begin
            if (i_sel_valid && !r_matched[w_sel_addr] && (w_sel_addr != r_addr_a)) begin
               w_accept = 1'b1;
               w_next   = READ_B;
            end
         end
         READ_B: w_next = COMPARE;
         COMPARE: begin
            if (r_sym_a == r_sym_b) begin
               w_match = 1'b1;
               w_next  = (&(r_matched | w_pair_mask)) ? DONE : PICK_A;
            end else begin
               w_show_load = 1'b1;
               w_next      = SHOW;
            end
         end
         SHOW: begin
            if (r_cnt == '0) begin
               w_show_end = 1'b1;
               w_next     = PICK_A;
            end
         end
         DONE:    w_next = DONE;
         default: w_next = PICK_A;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_addr     <= '0;
         r_addr_a      <= '0;
         r_face_up     <= '0;
         r_matched     <= '0;
         r_sym_a       <= '0;
         r_sym_b       <= '0;
         r_player      <= 1'b0;
         r_score0      <= '0;
         r_score1      <= '0;
         r_match_pulse <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_match_pulse <= w_match;
         if (w_accept) begin
            r_rd_addr              <= w_sel_addr;
            r_face_up[w_sel_addr]  <= 1'b1;
            if (r_state == PICK_A) r_addr_a <= w_sel_addr;
         end
         if (r_state == READ_A) r_sym_a <= i_rd_data;
         if (r_state == READ_B) r_sym_b <= i_rd_data;
         if (w_match) begin
            r_matched <= r_matched | w_pair_mask;
            // scores saturate rather than wrap
            if (!r_player) begin
               if (r_score0 != '1) r_score0 <= r_score0 + 1'b1;
            end else begin
               if (r_score1 != '1) r_score1 <= r_score1 + 1'b1;
            end
         end
         if (w_show_load)
            r_cnt <= CNT_W'(SHOW_CYCLES - 1);
         else if (r_state == SHOW && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
         if (w_show_end) begin
            r_face_up <= r_face_up & ~w_pair_mask;
            r_player  <= ~r_player;
         end
      end
   end

   assign o_rd_addr     = r_rd_addr;
   assign o_face_up     = r_face_up;
   assign o_matched     = r_matched;
   assign o_sym_a       = r_sym_a;
   assign o_sym_b       = r_sym_b;
   assign o_player      = r_player;
   assign o_score0      = r_score0;
   assign o_score1      = r_score1;
   assign o_match_pulse = r_match_pulse;
   assign o_busy        = (r_state == READ_A) || (r_state == READ_B) ||
                          (r_state == COMPARE) || (r_state == SHOW);
   assign o_game_over   = (r_state == DONE);

endmodule

// File: tb/tb_memory_match_ctrl.sv
// Bench for memory_match_ctrl: directed game scenarios plus a randomized full game,
// checked against a card-level model of the rules.
module tb_memory_match_ctrl;
   localparam int SYM_W = 3, SHOW_CYCLES = 8, SCORE_W = 4;

   logic               i_clk = 1'b0, i_rst_n = 1'b0, i_sel_valid = 1'b0;
   logic [1:0]         i_sel_row = '0, i_sel_col = '0;
   logic [3:0]         o_rd_addr;
   logic [SYM_W-1:0]   i_rd_data;
   logic [15:0]        o_face_up, o_matched;
   logic [SYM_W-1:0]   o_sym_a, o_sym_b;
   logic               o_player, o_match_pulse, o_busy, o_game_over;
   logic [SCORE_W-1:0] o_score0, o_score1;

   logic [SYM_W-1:0] board [16];
   assign i_rd_data = board[o_rd_addr];

   memory_match_ctrl #(.SYM_W(SYM_W), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SCORE_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sel_valid(i_sel_valid),
      .i_sel_row(i_sel_row), .i_sel_col(i_sel_col), .o_rd_addr(o_rd_addr),
      .i_rd_data(i_rd_data), .o_face_up(o_face_up), .o_matched(o_matched),
      .o_sym_a(o_sym_a), .o_sym_b(o_sym_b), .o_player(o_player),
      .o_score0(o_score0), .o_score1(o_score1), .o_match_pulse(o_match_pulse),
      .o_busy(o_busy), .o_game_over(o_game_over));

   always #5 i_clk = ~i_clk;

   int checks = 0, failures = 0;

   // model: phase 0 = first pick, 1 = second pick, 2 = resolving, 3 = game over
   logic [15:0] m_matched, m_face;
   int m_rd_addr, m_player, m_phase, m_first;
   int m_score [2];
   int abort_at = -1;
   bit aborted = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_matched = '0; m_face = '0; m_rd_addr = 0; m_player = 0;
      m_phase = 0; m_first = 0; m_score[0] = 0; m_score[1] = 0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_rd_addr"}, 32'(o_rd_addr), 0);
      chk({tag, "_face_up"}, 32'(o_face_up), 0);
      chk({tag, "_matched"}, 32'(o_matched), 0);
      chk({tag, "_syms"},    32'({o_sym_a, o_sym_b}), 0);
      chk({tag, "_scores"},  32'({o_score0, o_score1}), 0);
      chk({tag, "_flags"},   32'({o_player, o_match_pulse, o_busy, o_game_over}), 0);
   endtask

   task automatic chk_scores(input string tag);
      chk({tag, "_score0"}, 32'(o_score0), m_score[0]);
      chk({tag, "_score1"}, 32'(o_score1), m_score[1]);
      chk({tag, "_player"}, 32'(o_player), m_player);
   endtask

   // entered at the negedge where the DUT sits in COMPARE
   task automatic resolve(input int b);
      int a, n;
      bit done;
      a = m_first;
      if (board[a] == board[b]) begin
         @(negedge i_clk);
         m_matched[a] = 1'b1; m_matched[b] = 1'b1; m_face = m_matched;
         if (m_score[m_player] < (1 << SCORE_W) - 1) m_score[m_player]++;
         chk("match_pulse", 32'(o_match_pulse), 1);
         chk("match_matched", 32'(o_matched), 32'(m_matched));
         chk("match_face", 32'(o_face_up), 32'(m_face));
         chk_scores("match");
         m_phase = (m_matched == 16'hFFFF) ? 3 : 0;
         chk("match_game_over", 32'(o_game_over), (m_phase == 3) ? 1 : 0);
         @(negedge i_clk);
         chk("match_pulse_end", 32'(o_match_pulse), 0);
         chk("match_busy", 32'(o_busy), 0);
      end else begin
         n = 0; done = 0;
         for (int k = 0; k < 64 && !done; k++) begin
            i_sel_valid = (k == 2);
            i_sel_row = 2'($urandom_range(0, 3));
            i_sel_col = 2'($urandom_range(0, 3));
            @(negedge i_clk);
            i_sel_valid = 1'b0;
            if (k == abort_at) begin
               #2 i_rst_n = 1'b0;
               #1 chk_cleared("abort");
               model_reset();
               aborted = 1;
               return;
            end
            if (o_face_up[a] && o_face_up[b]) n++;
            else done = 1;
            chk("show_rd_addr", 32'(o_rd_addr), m_rd_addr);
         end
         chk("show_cycles", n, SHOW_CYCLES);
         m_face = m_matched;
         m_player = 1 - m_player;
         m_phase = 0;
         chk("show_face", 32'(o_face_up), 32'(m_face));
         chk("show_matched", 32'(o_matched), 32'(m_matched));
         chk_scores("show");
         chk("show_busy", 32'(o_busy), 0);
      end
   endtask

   // entered and left at a negedge
   task automatic pick(input int a);
      bit accept;
      accept = (m_phase == 0 || m_phase == 1) && !m_matched[a] &&
               !(m_phase == 1 && a == m_first);
      i_sel_valid = 1'b1;
      i_sel_row = 2'(a >> 2);
      i_sel_col = 2'(a & 3);
      @(negedge i_clk);
      i_sel_valid = 1'b0;
      if (accept) begin
         m_rd_addr = a;
         m_face[a] = 1'b1;
      end
      chk("pick_rd_addr", 32'(o_rd_addr), m_rd_addr);
      chk("pick_face", 32'(o_face_up), 32'(m_face));
      chk("pick_busy", 32'(o_busy), accept ? 1 : 0);
      if (accept) begin
         @(negedge i_clk);
         if (m_phase == 0) begin
            chk("sym_a", 32'(o_sym_a), 32'(board[a]));
            chk("pickb_busy", 32'(o_busy), 0);
            m_first = a;
            m_phase = 1;
         end else begin
            chk("sym_b", 32'(o_sym_b), 32'(board[a]));
            m_phase = 2;
            resolve(a);
         end
      end
   endtask

   function automatic int partner(input int a);
      for (int j = 0; j < 16; j++)
         if (j != a && board[j] == board[a]) return j;
      return a;
   endfunction

   function automatic int rand_unmatched();
      int c;
      for (int t = 0; t < 1000; t++) begin
         c = $urandom_range(0, 15);
         if (!m_matched[c]) return c;
      end
      for (int j = 0; j < 16; j++) if (!m_matched[j]) return j;
      return 0;
   endfunction

   task automatic reset_pulse();
      i_rst_n = 1'b0;
      #1 chk_cleared("rst");
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      int pos [16];
      int a, b, c, tmp, turns;
      bit want_match;
      for (int j = 0; j < 16; j++) board[j] = SYM_W'(j & 7);
      board[0] = 3; board[6] = 3; board[1] = 5; board[3] = 1; board[5] = 6;
      model_reset();

      // reset held with random picks
      for (int k = 0; k < 5; k++) begin
         i_sel_valid = 1'($urandom_range(0, 1));
         i_sel_row = 2'($urandom_range(0, 3));
         i_sel_col = 2'($urandom_range(0, 3));
         @(negedge i_clk);
         chk_cleared("reset_hold");
      end
      i_sel_valid = 1'b0;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("post_reset_player", 32'(o_player), 0);
      chk("post_reset_busy", 32'(o_busy), 0);

      // match of (0,0) and (1,2), then picks of matched cards are rejected
      pick(0); pick(6);
      chk("match_0041", 32'(o_matched), 32'h0041);
      chk("match_score0", 32'(o_score0), 1);
      chk("match_player0", 32'(o_player), 0);
      pick(0); pick(6);
      reset_pulse();

      // mismatch (0,0)=3 vs (0,1)=5 with a repeated first pick in between
      pick(0); pick(0);
      chk("dup_face", 32'(o_face_up), 32'h0001);
      pick(1);
      chk("mismatch_face", 32'(o_face_up), 0);
      chk("mismatch_player", 32'(o_player), 1);
      reset_pulse();

      // reset three cycles into SHOW, then a fresh game
      abort_at = 3;
      pick(0); pick(1);
      abort_at = -1;
      chk("abort_taken", 32'(aborted), 1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      pick(0); pick(6);
      chk("after_abort_score0", 32'(o_score0), 1);
      reset_pulse();

      // full randomized game on a shuffled board
      i_rst_n = 1'b0;
      for (int j = 0; j < 16; j++) pos[j] = j;
      for (int j = 15; j > 0; j--) begin
         c = $urandom_range(0, j);
         tmp = pos[j]; pos[j] = pos[c]; pos[c] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
         board[pos[2*k]] = SYM_W'(k);
         board[pos[2*k+1]] = SYM_W'(k);
      end
      #1 model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      turns = 0; want_match = 0;
      while (m_matched != 16'hFFFF && turns < 64) begin
         turns++;
         if (m_matched != 0 && $urandom_range(0, 3) == 0) begin
            for (int j = 0; j < 16; j++) if (m_matched[j]) begin c = j; break; end
            pick(c);
         end
         a = rand_unmatched();
         b = partner(a);
         pick(a);
         c = -1;
         for (int j = 0; j < 16; j++)
            if (!m_matched[j] && j != a && j != b) c = j;
         if (!want_match && c >= 0) begin
            if ($urandom_range(0, 1) == 1) pick(a);
            pick(c);
         end else begin
            pick(b);
         end
         want_match = !want_match;
      end
      chk("game_over", 32'(o_game_over), 1);
      chk("final_matched", 32'(o_matched), 32'hFFFF);
      chk("final_score_sum", 32'(o_score0) + 32'(o_score1), 8);
      for (int k = 0; k < 3; k++) pick($urandom_range(0, 15));
      chk("still_over", 32'(o_game_over), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
